// File: rtl/pulse_spacer_pkg.sv
// rtl/pulse_spacer_pkg.sv - shared types and constants for the pulse_spacer rate-shaping stage
package pulse_spacer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int DROP_CNT_W = 8;
    localparam int GAP_W      = $clog2(256);

    function automatic logic [DROP_CNT_W-1:0] sat_inc_drop(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sat_updown_cnt.sv
// rtl/sat_updown_cnt.sv - saturating up/down counter holding the queued event count
module sat_updown_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt,
    output logic             full,
    output logic             drop
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             empty;

    assign full  = &cnt_q;
    assign empty = (cnt_q == '0);
    // A simultaneous issue frees the slot the new event takes, so it is never a drop.
    assign drop  = inc & full & ~dec;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !dec && !full) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc && !empty) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pulse_spacer.sv
// rtl/pulse_spacer.sv - queues event requests and issues them as single-cycle pulses at least GAP+1 cycles apart
// Optional PULSE_SPACER_DROP_CNT_EN adds the saturating drop_cnt output.
module pulse_spacer
    import pulse_spacer_pkg::*;
#(
    parameter int CNT_W     = 4,
    parameter int GAP       = 3,
    parameter int T_CLKA_PS = 10000,
    parameter int T_CLKB_PS = 10000
) (
    input  logic             clkA,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             ev_in,
    output logic             pulse_out,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             ovf
`ifdef PULSE_SPACER_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic [GAP_W-1:0] gap_cnt_q;
    logic [GAP_W-1:0] gap_cnt_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             ovf_q;
    logic             ovf_d;

    logic             accept_req;
    logic             has_pending;
    logic             gap_last;
    logic             issue;
    logic             drop;
    logic             pending_full;

    // An event arriving together with clr is discarded, never counted as a drop.
    assign accept_req  = ev_in & ~clr;
    assign has_pending = (pending != '0);
    assign gap_last    = (state_q == ST_GAP) && (gap_cnt_q == '0);
    assign issue       = ~clr & has_pending & ((state_q == ST_IDLE) | gap_last);

    sat_updown_cnt #(
        .WIDTH(CNT_W)
    ) u_pending (
        .clk  (clkA),
        .rst_n(rst_n),
        .clr  (clr),
        .inc  (accept_req),
        .dec  (issue),
        .cnt  (pending),
        .full (pending_full),
        .drop (drop)
    );

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        pulse_d   = 1'b0;
        ovf_d     = drop;
        if (clr) begin
            state_d   = ST_IDLE;
            gap_cnt_d = '0;
            ovf_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (issue) begin
                        state_d = ST_PULSE;
                        pulse_d = 1'b1;
                    end
                end
                ST_PULSE: begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_W'(GAP - 1);
                end
                ST_GAP: begin
                    if (gap_last) begin
                        if (issue) begin
                            state_d = ST_PULSE;
                            pulse_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clkA or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
            pulse_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            pulse_q   <= pulse_d;
            ovf_q     <= ovf_d;
        end
    end

    assign pulse_out = pulse_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q != ST_IDLE) || has_pending;

`ifdef PULSE_SPACER_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    logic [DROP_CNT_W-1:0] drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr) begin
            drop_cnt_d = '0;
        end else if (drop) begin
            drop_cnt_d = sat_inc_drop(drop_cnt_q);
        end
    end

    always_ff @(posedge clkA or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

`ifndef SYNTHESIS
    // clkB must see each level change of the synchronizer toggle for two of its edges.
    if (GAP < 1 || GAP > 255 || (GAP + 1) * T_CLKA_PS < 2 * T_CLKB_PS) begin : g_cfg_err
        $error("pulse_spacer: GAP out of range or too short for the clkB period");
    end

    always_ff @(posedge clkA) begin
        if (rst_n) begin
            assert (!drop || pending_full);
        end
    end
`endif

endmodule

// File: tb/tb_pulse_spacer.sv
// tb/tb_pulse_spacer.sv - directed self-checking bench for pulse_spacer with GAP=3, CNT_W=4
module tb_pulse_spacer;

    localparam int CNT_W = 4;
    localparam int GAP   = 3;

    logic             clkA  = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr   = 1'b0;
    logic             ev_in = 1'b0;
    logic             pulse_out;
    logic [CNT_W-1:0] pending;
    logic             busy;
    logic             ovf;
`ifdef PULSE_SPACER_DROP_CNT_EN
    logic [7:0]       drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clkA = ~clkA;

    pulse_spacer #(
        .CNT_W(CNT_W),
        .GAP  (GAP)
    ) dut (
        .clkA     (clkA),
        .rst_n    (rst_n),
        .clr      (clr),
        .ev_in    (ev_in),
        .pulse_out(pulse_out),
        .pending  (pending),
        .busy     (busy),
        .ovf      (ovf)
`ifdef PULSE_SPACER_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    task automatic tick;
        @(posedge clkA);
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({pulse_out, pending, busy, ovf} !== 7'd0) begin
            errors++;
            $display("FAIL reset_values: got pulse=%0b pend=%0d busy=%0b ovf=%0b want all 0", pulse_out, pending, busy, ovf);
        end
`ifdef PULSE_SPACER_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt);
        end
`endif
        tick;
        tick;
        rst_n = 1'b1;
        tick;
        checks++;
        if ({pulse_out, pending, busy, ovf} !== 7'd0) begin
            errors++;
            $display("FAIL reset_release_idle: got pulse=%0b pend=%0d busy=%0b ovf=%0b want all 0", pulse_out, pending, busy, ovf);
        end
    endtask

    task automatic test_single;
        ev_in = 1'b1;
        tick;
        ev_in = 1'b0;
        checks++;
        if (pending !== 4'd1 || pulse_out !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: got pend=%0d pulse=%0b want pend=1 pulse=0", pending, pulse_out);
        end
        tick;
        checks++;
        if (pulse_out !== 1'b1 || pending !== 4'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_issue: got pulse=%0b pend=%0d busy=%0b want 1 0 1", pulse_out, pending, busy);
        end
        tick;
        checks++;
        if (pulse_out !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_width: got pulse=%0b busy=%0b want pulse=0 busy=1", pulse_out, busy);
        end
        tick;
        tick;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_last_gap_busy: got busy=%0b want 1", busy);
        end
        tick;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy=%0b want 0", busy);
        end
    endtask

    task automatic test_burst;
        logic [CNT_W-1:0] exp_pend [5];
        logic             exp_pulse;
        int               npulse;
        exp_pend = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd4};
        npulse   = 0;
        for (int e = 0; e < 30; e++) begin
            ev_in = (e < 5);
            tick;
            if (pulse_out === 1'b1) npulse++;
            if (e < 5) begin
                checks++;
                if (pending !== exp_pend[e]) begin
                    errors++;
                    $display("FAIL burst_pending e=%0d: got %0d want %0d", e, pending, exp_pend[e]);
                end
            end
            exp_pulse = (e == 1 || e == 5 || e == 9 || e == 13 || e == 17);
            checks++;
            if (pulse_out !== exp_pulse) begin
                errors++;
                $display("FAIL burst_pulse e=%0d: got %0b want %0b", e, pulse_out, exp_pulse);
            end
        end
        ev_in = 1'b0;
        checks++;
        if (npulse != 5 || busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_total: got pulses=%0d busy=%0b want 5 0", npulse, busy);
        end
    endtask

    task automatic test_overflow;
        int               npulse;
        int               novf;
        logic [CNT_W-1:0] maxp;
        npulse = 0;
        novf   = 0;
        maxp   = '0;
        for (int e = 0; e < 180; e++) begin
            ev_in = (e < 80);
            tick;
            if (pulse_out === 1'b1) npulse++;
            if (ovf === 1'b1) novf++;
            if (pending > maxp) maxp = pending;
            if (e == 20) begin
                checks++;
                if (ovf !== 1'b1 || pending !== 4'd15) begin
                    errors++;
                    $display("FAIL ovf_drop_edge: got ovf=%0b pend=%0d want 1 15", ovf, pending);
                end
            end
            if (e == 21) begin
                checks++;
                if (ovf !== 1'b0 || pending !== 4'd15 || pulse_out !== 1'b1) begin
                    errors++;
                    $display("FAIL full_issue_edge: got ovf=%0b pend=%0d pulse=%0b want 0 15 1", ovf, pending, pulse_out);
                end
            end
        end
        ev_in = 1'b0;
        checks++;
        if (maxp !== 4'd15) begin
            errors++;
            $display("FAIL ovf_saturate: got max pend=%0d want 15", maxp);
        end
        checks++;
        if (novf != 45 || npulse != 35) begin
            errors++;
            $display("FAIL ovf_counts: got drops=%0d pulses=%0d want 45 35", novf, npulse);
        end
        checks++;
        if (busy !== 1'b0 || pending !== 4'd0) begin
            errors++;
            $display("FAIL ovf_drain: got busy=%0b pend=%0d want 0 0", busy, pending);
        end
`ifdef PULSE_SPACER_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd45) begin
            errors++;
            $display("FAIL ovf_drop_cnt: got %0d want 45", drop_cnt);
        end
`endif
    endtask

    task automatic test_clear;
        int npulse;
        for (int e = 0; e < 4; e++) begin
            ev_in = 1'b1;
            tick;
        end
        checks++;
        if (pending !== 4'd3 || busy !== 1'b1 || pulse_out !== 1'b0) begin
            errors++;
            $display("FAIL clr_setup: got pend=%0d busy=%0b pulse=%0b want 3 1 0", pending, busy, pulse_out);
        end
        clr   = 1'b1;
        ev_in = 1'b1;
        tick;
        clr = 1'b0;
        checks++;
        if ({pulse_out, pending, busy, ovf} !== 7'd0) begin
            errors++;
            $display("FAIL clr_effect: got pulse=%0b pend=%0d busy=%0b ovf=%0b want all 0", pulse_out, pending, busy, ovf);
        end
`ifdef PULSE_SPACER_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("FAIL clr_drop_cnt: got %0d want 0", drop_cnt);
        end
`endif
        tick;
        ev_in = 1'b0;
        checks++;
        if (pending !== 4'd1 || pulse_out !== 1'b0) begin
            errors++;
            $display("FAIL clr_next_accept: got pend=%0d pulse=%0b want 1 0", pending, pulse_out);
        end
        tick;
        checks++;
        if (pulse_out !== 1'b1) begin
            errors++;
            $display("FAIL clr_next_issue: got pulse=%0b want 1", pulse_out);
        end
        npulse = 0;
        for (int e = 0; e < 12; e++) begin
            tick;
            if (pulse_out === 1'b1) npulse++;
        end
        checks++;
        if (npulse != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clr_no_extra: got extra pulses=%0d busy=%0b want 0 0", npulse, busy);
        end
    endtask

    task automatic test_reset_midrun;
        int npulse;
        ev_in = 1'b1;
        tick;
        tick;
        ev_in = 1'b0;
        checks++;
        if (pulse_out !== 1'b1 || pending !== 4'd1) begin
            errors++;
            $display("FAIL midrst_setup: got pulse=%0b pend=%0d want 1 1", pulse_out, pending);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pulse_out, pending, busy, ovf} !== 7'd0) begin
            errors++;
            $display("FAIL midrst_async: got pulse=%0b pend=%0d busy=%0b ovf=%0b want all 0", pulse_out, pending, busy, ovf);
        end
        tick;
        tick;
        rst_n  = 1'b1;
        npulse = 0;
        for (int e = 0; e < 20; e++) begin
            tick;
            if (pulse_out === 1'b1) npulse++;
        end
        checks++;
        if (npulse != 0 || busy !== 1'b0 || pending !== 4'd0) begin
            errors++;
            $display("FAIL midrst_quiet: got pulses=%0d busy=%0b pend=%0d want 0 0 0", npulse, busy, pending);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_burst;
        test_overflow;
        test_clear;
        test_reset_midrun;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
